bit_serial_operand_serializer: RTL
==================================

# bit_serial_operand_serializer

Upstream feeder for `bit_serial_multiplier`. It accepts parallel K-bit operand pairs over a valid/ready handshake and shifts each pair out LSB-first on `x`/`y` as one 2K-cycle frame. It also generates the `first_bit`/`last_bit` framing the multiplier slices use to reset and close each product. A one-entry holding buffer lets the next pair be accepted mid-frame, so frames can run back-to-back with no idle cycle.

## Interface
- `K`, default 8: operand width; the frame length is 2K cycles.
- `SIGNED`, default 0: padding mode. 0 zero-extends; 1 sign-extends the operands in frame cycles K..2K-1.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: an operand pair is offered.
- `in_ready` out 1: the block can take a pair; the transfer happens on a rising edge where `in_valid & in_ready`.
- `in_x` in K: multiplicand.
- `in_y` in K: multiplier.
- `x` out 1: serial multiplicand bit, registered.
- `y` out 1: serial multiplier bit, registered.
- `first_bit` out 1: high during frame cycle 0.
- `last_bit` out 1: high during frame cycle 2K-1.
- `active` out 1: a frame is being driven.

## Operation
- Internal state:
  - FSM with states IDLE and SHIFT.
  - Frame counter `cnt`, width clog2(2K), counting 0..2K-1.
  - Shift registers `sx`, `sy`, each 2K bits.
  - Holding buffer `hx`, `hy`, `h_valid`.
- Loading a pair (a, b):
  - `sx` = {pad(a), a} and `sy` = {pad(b), b}.
  - pad = K zeros when SIGNED=0; K copies of the operand MSB when SIGNED=1.
- Outputs:
  - `x` = `sx[0]`, `y` = `sy[0]`.
  - `first_bit` = SHIFT & (cnt==0); `last_bit` = SHIFT & (cnt==2K-1); `active` = SHIFT.
  - In IDLE, `x`, `y`, `first_bit` and `last_bit` are all 0.
- `in_ready` = ~`h_valid`, a registered term with no combinational path from `in_valid`.
- Transitions on each rising edge:
  - IDLE, accept: load the pair into `sx`/`sy`, set cnt=0, go to SHIFT.
  - SHIFT, cnt<2K-1: shift `sx`/`sy` right by one and increment cnt. An accept in this cycle writes the holding buffer and sets `h_valid`.
  - SHIFT, cnt==2K-1, `h_valid`=1: load from the holding buffer, clear `h_valid`, set cnt=0, stay in SHIFT. No accept is possible here because `in_ready`=0.
  - SHIFT, cnt==2K-1, `h_valid`=0 and accept: load the incoming pair directly (bypass), set cnt=0, stay in SHIFT.
  - SHIFT, cnt==2K-1, no pending pair: go to IDLE.
- `h_valid` is never set and cleared on the same edge. The buffer depth is exactly one.
- The serial side has no backpressure: once a frame starts it always runs all 2K cycles.
- Reset (asynchronous, any time, including mid-frame):
  - State returns to IDLE; cnt, `sx`, `sy`, `hx`, `hy` and `h_valid` all clear.
  - Outputs go to `x`=`y`=`first_bit`=`last_bit`=`active`=0 and `in_ready`=1.
  - A partially sent frame is abandoned. The next frame's `first_bit` resynchronises the multiplier, which has no reset of its own.

## Timing
- Latency: a pair accepted at edge t while IDLE puts bit 0 on `x`/`y`, with `first_bit`=1, in the cycle after edge t.
- Frame bit i appears in cycle t+1+i; `last_bit` is in cycle t+2K.
- Back-to-back frames: when the next pair is buffered or arrives in the last cycle of a frame, its `first_bit` cycle directly follows the `last_bit` cycle, with zero gap.
- Sustained throughput: one pair per 2K cycles.
- `in_ready` falls on the edge after a mid-frame accept and rises on the edge that loads from the buffer.
- `first_bit` and `last_bit` are never high in the same cycle, since K≥1 gives a frame of at least 2 cycles.

## Test plan
- **Unsigned single frame** (K=4, SIGNED=0, in_x=0xB, in_y=0x6, then idle):
  - `x` = 1,1,0,1,0,0,0,0 and `y` = 0,1,1,0,0,0,0,0.
  - `first_bit` in cycle 0 only, `last_bit` in cycle 7 only.
  - Then IDLE with all outputs 0.
- **Signed padding** (K=4, SIGNED=1, in_x=0xB, in_y=0x3):
  - `x` = 1,1,0,1,1,1,1,1 and `y` = 1,1,0,0,0,0,0,0.
- **Back-to-back via buffer** (K=4): pair A accepted, pair B offered in frame cycle 2.
  - B is accepted and `in_ready` is 0 during cycles 3..7.
  - B's `first_bit` comes in the cycle right after A's `last_bit`, and `in_ready` is 1 again in that cycle.
- **Bypass at frame end** (K=4): pair B first offered in cycle 7 of frame A.
  - B is accepted and its frame starts the next cycle with no gap.
  - `h_valid` never sets.
- **Reset mid-frame** (K=4): pair accepted, `rst_n` pulled low asynchronously in frame cycle 3.
  - All outputs go to 0 immediately and `in_ready`=1.
  - After release, a new pair 0x1/0x1 gives `x`=`y`=1,0,0,0,0,0,0,0 with a correct `first_bit`.
- **Held `in_valid` with stalled buffer** (K=4): `in_valid` kept high with three distinct pairs A, B, C.
  - Exactly one transfer happens per `in_ready` window.
  - Frames come out A, B, C in order, 24 contiguous `active` cycles, with no duplicated or dropped pair.

Source files
------------

// File: rtl/bit_serial_operand_serializer_if.sv
// Parallel operand-pair input and serial frame output of the operand serializer.
// Handshake: a pair transfers on a rising edge where in_valid & in_ready; in_valid with its data must
// then stay stable until that edge. in_ready is registered and never depends on in_valid in the same cycle.
interface bit_serial_operand_serializer_if #(
    parameter int K = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [K-1:0] in_x;
    logic [K-1:0] in_y;
    logic         x;
    logic         y;
    logic         first_bit;
    logic         last_bit;
    logic         active;

    modport master (
        output in_valid, in_x, in_y,
        input  in_ready, x, y, first_bit, last_bit, active
    );

    modport slave (
        input  in_valid, in_x, in_y,
        output in_ready, x, y, first_bit, last_bit, active
    );
endinterface

// File: rtl/bit_serial_operand_serializer.sv
// Turns parallel K-bit operand pairs into LSB-first 2K-cycle serial frames with first/last framing,
// using a one-deep holding buffer so consecutive frames run with no idle cycle between them.
module bit_serial_operand_serializer #(
    parameter int K      = 8,
    parameter int SIGNED = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    bit_serial_operand_serializer_if.slave bus,
    output logic                           dbg_state_o,
    output logic                           dbg_h_valid_o
);
    localparam int FW = 2 * K;
    localparam int CW = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [CW-1:0] LAST = CW'(FW - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   sx_q, sx_d;
    logic [FW-1:0]   sy_q, sy_d;
    logic [K-1:0]    hx_q, hx_d;
    logic [K-1:0]    hy_q, hy_d;
    logic            h_valid_q, h_valid_d;
    logic            accept;

    // Upper half is the extension the multiplier sees in frame cycles K..2K-1.
    function automatic logic [FW-1:0] frame_word(input logic [K-1:0] v);
        logic pad_bit;
        pad_bit = (SIGNED != 0) ? v[K-1] : 1'b0;
        return {{K{pad_bit}}, v};
    endfunction

    assign accept = bus.in_valid & ~h_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            hx_q      <= '0;
            hy_q      <= '0;
            h_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            hx_q      <= hx_d;
            hy_q      <= hy_d;
            h_valid_q <= h_valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        hx_d      = hx_q;
        hy_d      = hy_q;
        h_valid_d = h_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sx_d    = frame_word(bus.in_x);
                    sy_d    = frame_word(bus.in_y);
                end
            end
            SHIFT: begin
                if (cnt_q != LAST) begin
                    sx_d  = sx_q >> 1;
                    sy_d  = sy_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (accept) begin
                        hx_d      = bus.in_x;
                        hy_d      = bus.in_y;
                        h_valid_d = 1'b1;
                    end
                end else if (h_valid_q) begin
                    sx_d      = frame_word(hx_q);
                    sy_d      = frame_word(hy_q);
                    cnt_d     = '0;
                    h_valid_d = 1'b0;
                end else if (accept) begin
                    sx_d  = frame_word(bus.in_x);
                    sy_d  = frame_word(bus.in_y);
                    cnt_d = '0;
                end else begin
                    // Clearing the shifters keeps x/y at 0 in IDLE straight from the registers.
                    state_d = IDLE;
                    cnt_d   = '0;
                    sx_d    = '0;
                    sy_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.x         = sx_q[0];
    assign bus.y         = sy_q[0];
    assign bus.active    = (state_q == SHIFT);
    assign bus.first_bit = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.last_bit  = (state_q == SHIFT) && (cnt_q == LAST);
    assign bus.in_ready  = ~h_valid_q;

    assign dbg_state_o   = state_q;
    assign dbg_h_valid_o = h_valid_q;
endmodule
